// File: rtl/gate_servo_ctrl.sv
// Gate servo controller: frame-synchronous PWM generator with open/close
// ramping, hold-open timer, obstacle protection and pending-command capture.
module gate_servo_ctrl #(
   parameter int unsigned PERIOD      = 500000,
   parameter int unsigned PW_CLOSED   = 25000,
   parameter int unsigned PW_OPEN     = 50000,
   parameter int unsigned STEP        = 250,
   parameter int unsigned HOLD_FRAMES = 250
) (
   input  logic        clk_in,
   input  logic        rst_n,
   input  logic        cmd_open,
   input  logic        cmd_close,
   input  logic        obstacle,
   output logic        pwm_out,
   output logic [1:0]  state,
   output logic [18:0] pulse_width,
   output logic        frame_tick
);

   localparam int unsigned CNT_W   = 19;
   localparam int unsigned PW_W    = 19;
   localparam int unsigned ARITH_W = 20;
   localparam int unsigned HOLD_W  = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(PERIOD - 1);
   localparam logic [ARITH_W-1:0] PW_MIN    = ARITH_W'(PW_CLOSED);
   localparam logic [ARITH_W-1:0] PW_MAX    = ARITH_W'(PW_OPEN);
   localparam logic [ARITH_W-1:0] PW_STEP   = ARITH_W'(STEP);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

   typedef enum logic [1:0] {
      ST_CLOSED  = 2'd0,
      ST_OPENING = 2'd1,
      ST_OPEN    = 2'd2,
      ST_CLOSING = 2'd3
   } state_t;

   // Registered state
   logic [CNT_W-1:0]  count_q;
   logic              tick_q;
   logic              pwm_q;
   state_t            state_q;
   logic [PW_W-1:0]   pw_q;
   logic [HOLD_W-1:0] hold_q;
   logic              pend_open_q;
   logic              pend_close_q;

   // Next-state values
   logic [CNT_W-1:0]  count_d;
   state_t            state_d;
   logic [PW_W-1:0]   pw_d;
   logic [HOLD_W-1:0] hold_d;
   logic              pend_open_d;
   logic              pend_close_d;

   // Pending view including a command arriving on this very cycle
   logic              open_p;
   logic              close_p;
   logic [ARITH_W-1:0] pw_ext;
   logic [ARITH_W-1:0] pw_up;
   logic [ARITH_W-1:0] pw_dn;

   assign open_p  = pend_open_q  | cmd_open;
   assign close_p = pend_close_q | cmd_close;
   assign pw_ext  = {1'b0, pw_q};
   assign pw_up   = pw_ext + PW_STEP;
   assign pw_dn   = pw_ext - PW_STEP;

   // Frame counter wraps after the tick cycle
   assign count_d = tick_q ? '0 : count_q + CNT_W'(1);

   // Next-state, width ramp and hold timer; only advances on the frame boundary
   always_comb begin
      state_d      = state_q;
      pw_d         = pw_q;
      hold_d       = hold_q;
      pend_open_d  = open_p;
      pend_close_d = close_p;

      if (tick_q) begin
         pend_open_d  = 1'b0;
         pend_close_d = 1'b0;
         unique case (state_q)
            ST_CLOSED: begin
               if (open_p) state_d = ST_OPENING;
            end
            ST_OPENING: begin
               if (close_p && !open_p) begin
                  state_d = ST_CLOSING;
               end else if (pw_up >= PW_MAX) begin
                  pw_d    = PW_W'(PW_MAX);
                  state_d = ST_OPEN;
                  hold_d  = '0;
               end else begin
                  pw_d = PW_W'(pw_up);
               end
            end
            ST_OPEN: begin
               if (obstacle) begin
                  hold_d = '0;
               end else if ((close_p && !open_p) || (hold_q == HOLD_LAST)) begin
                  state_d = ST_CLOSING;
                  hold_d  = '0;
               end else begin
                  hold_d = hold_q + HOLD_W'(1);
               end
            end
            ST_CLOSING: begin
               if (obstacle || open_p) begin
                  state_d = ST_OPENING;
               end else if (pw_ext <= (PW_MIN + PW_STEP)) begin
                  pw_d    = PW_W'(PW_MIN);
                  state_d = ST_CLOSED;
               end else begin
                  pw_d = PW_W'(pw_dn);
               end
            end
            default: begin
               state_d = ST_CLOSED;
               pw_d    = PW_W'(PW_MIN);
            end
         endcase
      end
   end

   // State, counter and output registers with immediate async reset
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         count_q      <= '0;
         tick_q       <= 1'b0;
         pwm_q        <= 1'b0;
         state_q      <= ST_CLOSED;
         pw_q         <= PW_W'(PW_CLOSED);
         hold_q       <= '0;
         pend_open_q  <= 1'b0;
         pend_close_q <= 1'b0;
      end else begin
         count_q      <= count_d;
         tick_q       <= (count_d == CNT_LAST);
         pwm_q        <= (count_q < pw_q);
         state_q      <= state_d;
         pw_q         <= pw_d;
         hold_q       <= hold_d;
         pend_open_q  <= pend_open_d;
         pend_close_q <= pend_close_d;
      end
   end

   assign pwm_out     = pwm_q;
   assign state       = state_q;
   assign pulse_width = pw_q;
   assign frame_tick  = tick_q;

endmodule

// File: tb/tb_gate_servo_ctrl.sv
// Directed bench for gate_servo_ctrl with small frame parameters.
module tb_gate_servo_ctrl;

   localparam int unsigned PERIOD      = 100;
   localparam int unsigned PW_CLOSED   = 10;
   localparam int unsigned PW_OPEN     = 20;
   localparam int unsigned STEP        = 5;
   localparam int unsigned HOLD_FRAMES = 3;

   localparam int S_CLOSED  = 0;
   localparam int S_OPENING = 1;
   localparam int S_OPEN    = 2;
   localparam int S_CLOSING = 3;

   logic        clk_in    = 1'b0;
   logic        rst_n     = 1'b0;
   logic        cmd_open  = 1'b0;
   logic        cmd_close = 1'b0;
   logic        obstacle  = 1'b0;
   logic        pwm_out;
   logic [1:0]  state;
   logic [18:0] pulse_width;
   logic        frame_tick;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   typedef struct {
      int st;
      int pw;
      int highs;
      int tick_at;
   } exp_t;

   exp_t sb[$];

   gate_servo_ctrl #(
      .PERIOD      (PERIOD),
      .PW_CLOSED   (PW_CLOSED),
      .PW_OPEN     (PW_OPEN),
      .STEP        (STEP),
      .HOLD_FRAMES (HOLD_FRAMES)
   ) dut (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .cmd_open    (cmd_open),
      .cmd_close   (cmd_close),
      .obstacle    (obstacle),
      .pwm_out     (pwm_out),
      .state       (state),
      .pulse_width (pulse_width),
      .frame_tick  (frame_tick)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // One aligned frame: expectations queued up front, compared after 100 cycles
   task automatic run_frame(input string tag, input int exp_st, input int exp_pw,
                            input int cmd_at, input logic op, input logic cl);
      exp_t e;
      int   highs   = 0;
      int   ticks   = 0;
      int   tick_at = -1;
      int   stable  = 1;
      e.st = exp_st; e.pw = exp_pw; e.highs = exp_pw; e.tick_at = int'(PERIOD) - 2;
      sb.push_back(e);
      for (int k = 0; k < int'(PERIOD); k++) begin
         if (k == cmd_at) begin
            cmd_open  = op;
            cmd_close = cl;
         end else begin
            cmd_open  = 1'b0;
            cmd_close = 1'b0;
         end
         if (k == 0) begin
            check({tag, "/state"}, 32'(state), 32'(exp_st));
            check({tag, "/pw"}, 32'(pulse_width), 32'(exp_pw));
         end
         step();
         if (pwm_out === 1'b1) highs++;
         if (frame_tick === 1'b1) begin
            ticks++;
            tick_at = k;
         end
         if (k < int'(PERIOD) - 1 &&
             (state !== 2'(exp_st) || pulse_width !== 19'(exp_pw))) stable = 0;
      end
      cmd_open  = 1'b0;
      cmd_close = 1'b0;
      e = sb.pop_front();
      check({tag, "/pulse_len"}, 32'(highs), 32'(e.highs));
      check({tag, "/tick_count"}, 32'(ticks), 32'd1);
      check({tag, "/tick_pos"}, 32'(tick_at), 32'(e.tick_at));
      check({tag, "/stable"}, 32'(stable), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "/pwm"}, 32'(pwm_out), 32'd0);
      check({tag, "/state"}, 32'(state), 32'(S_CLOSED));
      check({tag, "/pw"}, 32'(pulse_width), 32'(PW_CLOSED));
      check({tag, "/tick"}, 32'(frame_tick), 32'd0);
   endtask

   initial begin
      // Power-on reset
      rst_n = 1'b0;
      repeat (3) step();
      check_reset_outputs("por");
      rst_n = 1'b1;

      // Idle closed; a close in CLOSED is consumed silently, then open mid-frame
      run_frame("idle",      S_CLOSED,  10, 20, 1'b0, 1'b1);
      run_frame("open_req",  S_CLOSED,  10, 40, 1'b1, 1'b0);
      run_frame("ramp_up0",  S_OPENING, 10, -1, 1'b0, 1'b0);
      run_frame("ramp_up1",  S_OPENING, 15, -1, 1'b0, 1'b0);
      run_frame("hold0",     S_OPEN,    20, -1, 1'b0, 1'b0);
      run_frame("hold1",     S_OPEN,    20, 10, 1'b1, 1'b0);
      run_frame("hold2",     S_OPEN,    20, -1, 1'b0, 1'b0);
      run_frame("ramp_dn0",  S_CLOSING, 20, -1, 1'b0, 1'b0);
      run_frame("ramp_dn1",  S_CLOSING, 15, -1, 1'b0, 1'b0);

      // Reopen, let it auto-close, then hit an obstacle mid-close
      run_frame("reopen",    S_CLOSED,  10, 60, 1'b1, 1'b0);
      run_frame("ro_up0",    S_OPENING, 10, -1, 1'b0, 1'b0);
      run_frame("ro_up1",    S_OPENING, 15, -1, 1'b0, 1'b0);
      run_frame("ro_hold0",  S_OPEN,    20, -1, 1'b0, 1'b0);
      run_frame("ro_hold1",  S_OPEN,    20, -1, 1'b0, 1'b0);
      run_frame("ro_hold2",  S_OPEN,    20, -1, 1'b0, 1'b0);
      run_frame("ro_dn0",    S_CLOSING, 20, -1, 1'b0, 1'b0);
      obstacle = 1'b1;
      run_frame("obs_dn1",   S_CLOSING, 15, -1, 1'b0, 1'b0);
      run_frame("obs_rev",   S_OPENING, 15, -1, 1'b0, 1'b0);
      for (int f = 0; f < 5; f++)
         run_frame($sformatf("obs_open%0d", f), S_OPEN, 20, (f == 1) ? 30 : -1, 1'b0, 1'b1);
      obstacle = 1'b0;

      // Close arriving on the tick cycle itself applies at that boundary
      run_frame("close_tick", S_OPEN,    20, int'(PERIOD) - 1, 1'b0, 1'b1);
      run_frame("ct_dn0",     S_CLOSING, 20, -1, 1'b0, 1'b0);
      run_frame("ct_dn1",     S_CLOSING, 15, -1, 1'b0, 1'b0);

      // Simultaneous open and close while closed: open wins
      run_frame("both",       S_CLOSED,  10, 50, 1'b1, 1'b1);
      run_frame("both_up0",   S_OPENING, 10, -1, 1'b0, 1'b0);

      // Mid-ramp reset during the high part of the pulse
      check("mr/state_pre", 32'(state), 32'(S_OPENING));
      check("mr/pw_pre", 32'(pulse_width), 32'd15);
      repeat (5) step();
      check("mr/pwm_pre", 32'(pwm_out), 32'd1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mr_now");
      repeat (4) step();
      check_reset_outputs("mr_held");
      rst_n = 1'b1;
      run_frame("post_rst",   S_CLOSED,  10, -1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
